// File: rtl/vec_pack_if.sv
// Handshake bundle between the scalar producer, vec_pack_ctrl and the vector write port.
// The s_last signal exists only when VEC_PACK_EARLY_LAST_EN is defined.
interface vec_pack_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32
);
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W = LANES * LANE_W;

    logic             start;
    logic [VEC_W-1:0] base_vec;
    logic             s_valid;
    logic             s_ready;
    logic [LANE_W-1:0] s_data;
`ifdef VEC_PACK_EARLY_LAST_EN
    logic             s_last;
`endif
    logic             v_valid;
    logic             v_ready;
    logic [VEC_W-1:0] v_data;
    logic [SEL_W-1:0] lane_idx;
    logic             busy;

    modport master (
`ifdef VEC_PACK_EARLY_LAST_EN
        output s_last,
`endif
        output start, base_vec, s_valid, s_data, v_ready,
        input  s_ready, v_valid, v_data, lane_idx, busy
    );

    modport slave (
`ifdef VEC_PACK_EARLY_LAST_EN
        input  s_last,
`endif
        input  start, base_vec, s_valid, s_data, v_ready,
        output s_ready, v_valid, v_data, lane_idx, busy
    );
endinterface

// File: rtl/vec_pack_ctrl.sv
// Packs LANES scalars into one vector, one lane per accepted beat, then offers it downstream.
// Define VEC_PACK_EARLY_LAST_EN to let a beat with s_last close the pack before all lanes are filled.
module vec_pack_ctrl #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    vec_pack_if.slave  bus
);
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W = LANES * LANE_W;
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [VEC_W-1:0] acc_q, acc_d;
    logic [SEL_W-1:0] lane_q, lane_d;
    logic             beat_last;

`ifdef VEC_PACK_EARLY_LAST_EN
    assign beat_last = (lane_q == LAST_LANE) || bus.s_last;
`else
    assign beat_last = (lane_q == LAST_LANE);
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            // NOTE: the accumulator is reset too, because v_data must read zero out of reset.
            acc_q   <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lane_q  <= lane_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        lane_d  = lane_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.base_vec;
                    lane_d  = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (bus.s_valid) begin
                    acc_d[lane_q*LANE_W +: LANE_W] = bus.s_data;
                    if (beat_last) begin
                        lane_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // start in the handshake cycle is deliberately not looked at here.
                if (bus.v_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags come from the registered state only; no s_valid/v_ready feed-through.
    assign bus.s_ready  = (state_q == ST_FILL);
    assign bus.v_valid  = (state_q == ST_DONE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.v_data   = acc_q;
    assign bus.lane_idx = lane_q;

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.s_ready && bus.v_valid));

    a_vec_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.v_valid && !bus.v_ready) |=> (bus.v_valid && $stable(bus.v_data)));

    a_lane_in_range: assert property (@(posedge clk) disable iff (rst)
        (bus.lane_idx <= LAST_LANE));
endmodule

// File: tb/tb_vec_pack_ctrl.sv
// Randomized bench for vec_pack_ctrl: directed packs plus random base/data/gaps/backpressure,
// checked against a lane-overwrite reference computed from base_vec and the accepted scalars.
module tb_vec_pack_ctrl;
    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int VEC_W  = LANES * LANE_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vec_pack_if #(.LANES(LANES), .LANE_W(LANE_W)) vif ();

    vec_pack_ctrl #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [LANE_W-1:0] pk_data [LANES];

    task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic set_last(input logic v);
`ifdef VEC_PACK_EARLY_LAST_EN
        vif.s_last = v;
`else
        if (v) $display("note: s_last requested without early-last build");
`endif
    endtask

    // One complete pack of n beats. Inputs change on the falling edge and outputs are
    // sampled there too, so each @(negedge) spans exactly one rising edge of the DUT.
    task automatic run_pack(input logic [VEC_W-1:0] base, input int n, input int gap_at,
                            input int gap_len, input int bp, input bit noise);
        logic [VEC_W-1:0] exp;
        exp = base;
        for (int k = 0; k < n; k++) exp[k*LANE_W +: LANE_W] = pk_data[k];

        check("idle_busy", vif.busy, 0);
        vif.start    = 1'b1;
        vif.base_vec = base;
        @(negedge clk);
        vif.start = 1'b0;
        check("fill_s_ready", vif.s_ready, 1);
        check("fill_busy", vif.busy, 1);

        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    vif.s_valid = 1'b0;
                    vif.s_data  = $urandom;
                    @(negedge clk);
                    check("gap_lane_hold", vif.lane_idx, k);
                    check("gap_no_vvalid", vif.v_valid, 0);
                end
            end
            check("accept_lane", vif.lane_idx, k);
            check("accept_s_ready", vif.s_ready, 1);
            vif.s_valid = 1'b1;
            vif.s_data  = pk_data[k];
            set_last(k == n - 1 && n < LANES);
            @(negedge clk);
        end
        vif.s_valid = 1'b0;
        set_last(1'b0);

        check("v_valid_latency", vif.v_valid, 1);
        check("v_data", vif.v_data, exp);
        check("done_lane_zero", vif.lane_idx, 0);
        check("done_s_ready", vif.s_ready, 0);

        for (int b = 0; b < bp; b++) begin
            if (noise) begin
                vif.start   = 1'b1;
                vif.s_valid = 1'b1;
                vif.s_data  = $urandom;
            end
            @(negedge clk);
            check("bp_v_valid", vif.v_valid, 1);
            check("bp_v_data", vif.v_data, exp);
            check("bp_s_ready", vif.s_ready, 0);
        end

        vif.s_valid = 1'b0;
        vif.v_ready = 1'b1;
        vif.start   = noise;
        @(negedge clk);
        vif.v_ready = 1'b0;
        vif.start   = 1'b0;
        check("post_hs_busy", vif.busy, 0);
        check("post_hs_v_valid", vif.v_valid, 0);
    endtask

    initial begin
        logic [VEC_W-1:0] dbase;
        int n;

        vif.start    = 1'b0;
        vif.base_vec = '0;
        vif.s_valid  = 1'b0;
        vif.s_data   = '0;
        vif.v_ready  = 1'b0;
        set_last(1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", vif.busy, 0);
        check("rst_s_ready", vif.s_ready, 0);
        check("rst_v_valid", vif.v_valid, 0);
        check("rst_lane", vif.lane_idx, 0);
        check("rst_v_data", vif.v_data, 0);
        rst = 1'b0;
        @(negedge clk);

        dbase   = 128'h00000000_000FF000_01020304_0000AAAA;
        pk_data = '{32'h1CA, 32'h11, 32'h22, 32'h33};
        run_pack(dbase, LANES, -1, 0, 0, 1'b0);
        run_pack(dbase, LANES, 2, 3, 0, 1'b0);
        run_pack(dbase, LANES, -1, 0, 5, 1'b1);

        // Reset after two accepted beats discards the partial pack.
        vif.start    = 1'b1;
        vif.base_vec = dbase;
        @(negedge clk);
        vif.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vif.s_valid = 1'b1;
            vif.s_data  = pk_data[k];
            @(negedge clk);
        end
        vif.s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", vif.busy, 0);
        check("midrst_s_ready", vif.s_ready, 0);
        check("midrst_v_valid", vif.v_valid, 0);
        check("midrst_lane", vif.lane_idx, 0);
        pk_data = '{32'hA, 32'hA, 32'hA, 32'hA};
        run_pack('0, LANES, -1, 0, 0, 1'b0);

`ifdef VEC_PACK_EARLY_LAST_EN
        pk_data[0] = 32'h1CA;
        run_pack(dbase, 1, -1, 0, 0, 1'b0);
`endif

        repeat (40) begin
            dbase = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < LANES; k++) pk_data[k] = $urandom;
`ifdef VEC_PACK_EARLY_LAST_EN
            n = $urandom_range(1, LANES);
`else
            n = LANES;
`endif
            run_pack(dbase, n, $urandom_range(0, LANES - 1), $urandom_range(0, 3),
                     $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench did not finish in time");
    end
endmodule
